// File: rtl/store_buffer.sv
// Posted-write store buffer between the datapath store path and dm.
// Ports: Clk/Reset; St* push side; Ld* forwarding load side;
// Dm* shared dm port; Count/Empty/Full occupancy status.
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 10,
  parameter int DW    = 32
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     StValid,
  input  logic [AW-1:0]            StAddr,
  input  logic [DW-1:0]            StData,
  output logic                     StReady,
  input  logic                     LdValid,
  input  logic [AW-1:0]            LdAddr,
  output logic [DW-1:0]            LdData,
  output logic                     LdHit,
  output logic [AW-1:0]            DmAddr,
  output logic [DW-1:0]            DmData,
  output logic                     DmWrite,
  output logic                     DmRead,
  input  logic [DW-1:0]            DmOut,
  output logic [$clog2(DEPTH):0]   Count,
  output logic                     Empty,
  output logic                     Full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] r_addr [DEPTH];
  logic [DW-1:0] r_data [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;

  logic          w_push;
  logic          w_drain;
  logic          w_hit;
  logic [DW-1:0] w_fwd;

  assign Count   = r_count;
  assign Empty   = (r_count == '0);
  assign Full    = (r_count == CW'(DEPTH));
  assign StReady = !Full;
  assign w_push  = StValid & StReady;
  // Loads own the dm port; drain only when it is free.
  assign w_drain = !Empty & !LdValid;
  assign DmWrite = w_drain;
  assign DmRead  = LdValid;
  assign DmAddr  = LdValid ? LdAddr : r_addr[r_head];
  assign DmData  = r_data[r_head];

  // Walk oldest to youngest so the last match (youngest) wins.
  always_comb begin
    w_hit = 1'b0;
    w_fwd = '0;
    for (int i = 0; i < DEPTH; i++) begin
      logic [PW-1:0] idx;
      idx = r_head + PW'(i);
      if ((CW'(i) < r_count) && (r_addr[idx] == LdAddr)) begin
        w_hit = 1'b1;
        w_fwd = r_data[idx];
      end
    end
  end

  assign LdHit  = LdValid & w_hit;
  assign LdData = LdHit ? w_fwd : DmOut;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push)
        r_tail <= r_tail + PW'(1);
      if (w_drain)
        r_head <= r_head + PW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_drain);
    end
  end

  // Entry contents need no reset; validity comes from Count.
  always_ff @(posedge Clk) begin
    if (w_push) begin
      r_addr[r_tail] <= StAddr;
      r_data[r_tail] <= StData;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed self-checking bench for store_buffer with a dm model.
// dm: combinational read of DmAddr, write on posedge when DmWrite.
module tb_store_buffer;

  logic        Clk;
  logic        Reset;
  logic        StValid;
  logic [9:0]  StAddr;
  logic [31:0] StData;
  logic        StReady;
  logic        LdValid;
  logic [9:0]  LdAddr;
  logic [31:0] LdData;
  logic        LdHit;
  logic [9:0]  DmAddr;
  logic [31:0] DmData;
  logic        DmWrite;
  logic        DmRead;
  logic [31:0] DmOut;
  logic [2:0]  Count;
  logic        Empty;
  logic        Full;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem [1024];
  logic [9:0]  log_a [$];
  logic [31:0] log_d [$];

  store_buffer #(.DEPTH(4), .AW(10), .DW(32)) dut (
    .Clk(Clk), .Reset(Reset),
    .StValid(StValid), .StAddr(StAddr), .StData(StData),
    .StReady(StReady),
    .LdValid(LdValid), .LdAddr(LdAddr),
    .LdData(LdData), .LdHit(LdHit),
    .DmAddr(DmAddr), .DmData(DmData),
    .DmWrite(DmWrite), .DmRead(DmRead), .DmOut(DmOut),
    .Count(Count), .Empty(Empty), .Full(Full)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  assign DmOut = mem[DmAddr];

  always @(posedge Clk) begin
    if (DmWrite) begin
      mem[DmAddr] <= DmData;
      log_a.push_back(DmAddr);
      log_d.push_back(DmData);
    end
  end

  task automatic step();
    @(posedge Clk);
    @(negedge Clk);
    #1;
  endtask

  task automatic clr_log();
    log_a.delete();
    log_d.delete();
  endtask

  task automatic test_reset();
    Reset = 1'b1; StValid = 1'b0; LdValid = 1'b0;
    StAddr = '0; StData = '0; LdAddr = '0;
    step(); step();
    Reset = 1'b0;
    #1;
    total++;
    if (Count !== 3'd0 || Empty !== 1'b1 || Full !== 1'b0) begin
      bad++;
      $display("FAIL reset_occ: count=%0d empty=%b full=%b want 0/1/0",
               Count, Empty, Full);
    end
    total++;
    if (StReady !== 1'b1 || DmWrite !== 1'b0 || LdHit !== 1'b0) begin
      bad++;
      $display("FAIL reset_out: stready=%b dmwrite=%b ldhit=%b want 1/0/0",
               StReady, DmWrite, LdHit);
    end
    clr_log();
  endtask

  task automatic test_single();
    StValid = 1'b1; StAddr = 10'd5; StData = 32'h11111111;
    #1;
    total++;
    if (DmWrite !== 1'b0) begin
      bad++;
      $display("FAIL single_nodrain: dmwrite=%b want 0", DmWrite);
    end
    step();
    StValid = 1'b0;
    #1;
    total++;
    if (Count !== 3'd1 || DmWrite !== 1'b1 || DmAddr !== 10'd5 ||
        DmData !== 32'h11111111) begin
      bad++;
      $display("FAIL single_drain: count=%0d dmwrite=%b addr=%0d data=%h want 1/1/5/11111111",
               Count, DmWrite, DmAddr, DmData);
    end
    step();
    total++;
    if (mem[5] !== 32'h11111111 || Empty !== 1'b1 || log_a.size() != 1) begin
      bad++;
      $display("FAIL single_commit: dm5=%h empty=%b writes=%0d want 11111111/1/1",
               mem[5], Empty, log_a.size());
    end
    clr_log();
  endtask

  task automatic test_full();
    LdValid = 1'b1; LdAddr = 10'd0;
    for (int i = 1; i <= 4; i++) begin
      StValid = 1'b1; StAddr = 10'(i); StData = 32'h100 + 32'(i);
      step();
    end
    StValid = 1'b0;
    #1;
    total++;
    if (Full !== 1'b1 || StReady !== 1'b0 || DmWrite !== 1'b0 ||
        LdHit !== 1'b0) begin
      bad++;
      $display("FAIL full_flags: full=%b stready=%b dmwrite=%b ldhit=%b want 1/0/0/0",
               Full, StReady, DmWrite, LdHit);
    end
    LdAddr = 10'd3;
    #1;
    total++;
    if (LdHit !== 1'b1 || LdData !== 32'h103) begin
      bad++;
      $display("FAIL full_fwd: hit=%b data=%h want 1/00000103", LdHit, LdData);
    end
    StValid = 1'b1; StAddr = 10'd6; StData = 32'hDEAD0006;
    step();
    total++;
    if (Count !== 3'd4) begin
      bad++;
      $display("FAIL full_refuse: count=%0d want 4", Count);
    end
    LdValid = 1'b0;
    step();
    StValid = 1'b0;
    #1;
    total++;
    if (Count !== 3'd3) begin
      bad++;
      $display("FAIL full_refuse_drain: count=%0d want 3", Count);
    end
    step(); step(); step();
    total++;
    if (log_a.size() != 4 || Empty !== 1'b1) begin
      bad++;
      $display("FAIL full_drain_cnt: writes=%0d empty=%b want 4/1",
               log_a.size(), Empty);
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (log_a[i] !== 10'(i + 1) || log_d[i] !== 32'h101 + 32'(i)) begin
          bad++;
          $display("FAIL full_order%0d: addr=%0d data=%h want %0d/%h",
                   i, log_a[i], log_d[i], i + 1, 32'h101 + 32'(i));
        end
      end
    end
    clr_log();
  endtask

  task automatic test_same_addr();
    LdValid = 1'b1; LdAddr = 10'd7;
    StValid = 1'b1; StAddr = 10'd7; StData = 32'hAAAA0000;
    #1;
    total++;
    if (LdHit !== 1'b0) begin
      bad++;
      $display("FAIL same_cycle_vis: hit=%b want 0", LdHit);
    end
    step();
    StData = 32'hBBBB0000;
    #1;
    total++;
    if (LdHit !== 1'b1 || LdData !== 32'hAAAA0000) begin
      bad++;
      $display("FAIL same_first: hit=%b data=%h want 1/aaaa0000", LdHit, LdData);
    end
    step();
    StValid = 1'b0;
    #1;
    total++;
    if (LdHit !== 1'b1 || LdData !== 32'hBBBB0000 || DmAddr !== 10'd7) begin
      bad++;
      $display("FAIL same_youngest: hit=%b data=%h dmaddr=%0d want 1/bbbb0000/7",
               LdHit, LdData, DmAddr);
    end
    LdValid = 1'b0;
    step(); step();
    total++;
    if (mem[7] !== 32'hBBBB0000 || log_d.size() != 2) begin
      bad++;
      $display("FAIL same_final: dm7=%h writes=%0d want bbbb0000/2",
               mem[7], log_d.size());
    end else begin
      total++;
      if (log_d[0] !== 32'hAAAA0000 || log_d[1] !== 32'hBBBB0000) begin
        bad++;
        $display("FAIL same_order: %h,%h want aaaa0000,bbbb0000",
                 log_d[0], log_d[1]);
      end
    end
    clr_log();
  endtask

  task automatic test_miss();
    mem[9] = 32'h12345678;
    LdValid = 1'b1; LdAddr = 10'd9;
    StValid = 1'b1; StAddr = 10'd8; StData = 32'h88888888;
    step();
    StValid = 1'b0;
    #1;
    total++;
    if (LdHit !== 1'b0 || LdData !== 32'h12345678 || DmAddr !== 10'd9 ||
        DmWrite !== 1'b0 || DmRead !== 1'b1 || Count !== 3'd1) begin
      bad++;
      $display("FAIL miss: hit=%b data=%h addr=%0d wr=%b rd=%b cnt=%0d want 0/12345678/9/0/1/1",
               LdHit, LdData, DmAddr, DmWrite, DmRead, Count);
    end
    LdValid = 1'b0;
    step();
    total++;
    if (mem[8] !== 32'h88888888 || Empty !== 1'b1) begin
      bad++;
      $display("FAIL miss_drain: dm8=%h empty=%b want 88888888/1", mem[8], Empty);
    end
    clr_log();
  endtask

  task automatic test_back_to_back();
    LdValid = 1'b1;
    LdAddr = 10'd0;
    for (int i = 0; i < 2; i++) begin
      StValid = 1'b1; StAddr = 10'(20 + i); StData = 32'hC0DE0000 + 32'(20 + i);
      step();
    end
    LdValid = 1'b0;
    for (int i = 2; i < 12; i++) begin
      StAddr = 10'(20 + i); StData = 32'hC0DE0000 + 32'(20 + i);
      step();
      total++;
      if (Count !== 3'd2) begin
        bad++;
        $display("FAIL b2b_count%0d: count=%0d want 2", i, Count);
      end
    end
    StValid = 1'b0;
    step(); step();
    total++;
    if (log_a.size() != 12 || Empty !== 1'b1) begin
      bad++;
      $display("FAIL b2b_writes: writes=%0d empty=%b want 12/1",
               log_a.size(), Empty);
    end else begin
      for (int i = 0; i < 12; i++) begin
        total++;
        if (log_a[i] !== 10'(20 + i) ||
            log_d[i] !== 32'hC0DE0000 + 32'(20 + i)) begin
          bad++;
          $display("FAIL b2b_order%0d: addr=%0d data=%h want %0d/%h",
                   i, log_a[i], log_d[i], 20 + i, 32'hC0DE0000 + 32'(20 + i));
        end
      end
    end
    clr_log();
  endtask

  task automatic test_reset_mid();
    LdValid = 1'b1; LdAddr = 10'd0;
    for (int i = 0; i < 3; i++) begin
      StValid = 1'b1; StAddr = 10'(40 + i); StData = 32'hFACE0000 + 32'(i);
      step();
    end
    total++;
    if (Count !== 3'd3) begin
      bad++;
      $display("FAIL rmid_pre: count=%0d want 3", Count);
    end
    Reset = 1'b1; StAddr = 10'd43; StData = 32'hFACE0003;
    step();
    Reset = 1'b0; StValid = 1'b0; LdValid = 1'b0;
    #1;
    total++;
    if (Count !== 3'd0 || Empty !== 1'b1 || DmWrite !== 1'b0) begin
      bad++;
      $display("FAIL rmid_post: count=%0d empty=%b dmwrite=%b want 0/1/0",
               Count, Empty, DmWrite);
    end
    step(); step();
    total++;
    if (log_a.size() != 0) begin
      bad++;
      $display("FAIL rmid_nowrite: writes=%0d want 0", log_a.size());
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    test_reset();
    test_single();
    test_full();
    test_same_addr();
    test_miss();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
